// File: rtl/snitch_regfile_writeback_pkg.sv
// Shared types and helpers for the Snitch register-file write-back block.
// wb_req_t is sized for the widest supported configuration; users fill only
// the low AddrWidth/DataWidth bits and the remaining bits stay zero.
package snitch_regfile_writeback_pkg;

    localparam int MaxAddrWidth = 16;
    localparam int MaxDataWidth = 64;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] addr;
        logic [MaxDataWidth-1:0] data;
    } wb_req_t;

    // Number of architectural registers addressed by an addr_width-bit index.
    function automatic int NumWords(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/snitch_regfile_writeback_rr_arb.sv
// Round-robin arbiter: the search starts at r_ptr, the first asserted request
// wins a one-hot grant, and the pointer moves just past the winner. With no
// request the pointer holds. The grant depends combinationally on req_i.
module snitch_regfile_writeback_rr_arb #(
    parameter int NrSources = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NrSources-1:0] req_i,
    output logic [NrSources-1:0] gnt_o
);

    localparam int PtrWidth = (NrSources > 1) ? $clog2(NrSources) : 1;

    logic [PtrWidth-1:0] r_ptr;
    logic [PtrWidth-1:0] w_ptr_next;
    logic                w_found;

    // Scan the requests in rotating priority order starting at the pointer.
    always_comb begin
        gnt_o      = '0;
        w_found    = 1'b0;
        w_ptr_next = r_ptr;
        for (int i = 0; i < NrSources; i++) begin
            if (!w_found && req_i[(int'(r_ptr) + i) % NrSources]) begin
                gnt_o[(int'(r_ptr) + i) % NrSources] = 1'b1;
                w_found    = 1'b1;
                w_ptr_next = PtrWidth'((int'(r_ptr) + i + 1) % NrSources);
            end
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/snitch_regfile_writeback.sv
// Write-side initiator for the Snitch register file: round-robin arbitration
// of write-back producers, a single registered write port and a busy
// scoreboard of destinations with writes in flight.
// Handshake: a source is accepted in the cycle where src_valid_i && src_ready_o;
// src_ready_o is one-hot or zero and always grants some valid source, because
// the register file never stalls. Requesters hold addr/data until accepted.
// Optional macro SNITCH_REGFILE_WRITEBACK_FWD_EN enables the forwarding
// query ports; without it fwd_hit_o/fwd_data_o are tied to zero.
module snitch_regfile_writeback
    import snitch_regfile_writeback_pkg::*;
#(
    parameter int NrSources   = 3,
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 5,
    parameter bit ZeroRegZero = 1'b1,
    parameter int NrReadPorts = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NrSources-1:0]                  src_valid_i,
    output logic [NrSources-1:0]                  src_ready_o,
    input  logic [NrSources-1:0][AddrWidth-1:0]   src_addr_i,
    input  logic [NrSources-1:0][DataWidth-1:0]   src_data_i,
    input  logic                                  sb_set_valid_i,
    input  logic [AddrWidth-1:0]                  sb_set_addr_i,
    output logic [NumWords(AddrWidth)-1:0]        busy_o,
    output logic [AddrWidth-1:0]                  waddr_o,
    output logic [DataWidth-1:0]                  wdata_o,
    output logic                                  we_o,
    input  logic [NrReadPorts-1:0][AddrWidth-1:0] fwd_raddr_i,
    output logic [NrReadPorts-1:0]                fwd_hit_o,
    output logic [NrReadPorts-1:0][DataWidth-1:0] fwd_data_o
);

    localparam int Words = NumWords(AddrWidth);

    logic [NrSources-1:0] w_gnt;
    logic                 w_accept;
    logic                 w_write;
    wb_req_t              w_sel;
    wb_req_t              r_out;
    logic                 r_we;
    logic [Words-1:0]     r_busy;
    logic [Words-1:0]     w_set;
    logic [Words-1:0]     w_clr;
    logic                 w_unused_stage;

    snitch_regfile_writeback_rr_arb #(
        .NrSources (NrSources)
    ) i_rr_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (src_valid_i),
        .gnt_o  (w_gnt)
    );

    assign src_ready_o = w_gnt;
    assign w_accept    = |w_gnt;

    // Mux the granted source's request into a write-back record.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NrSources; i++) begin
            if (w_gnt[i]) begin
                w_sel.addr[AddrWidth-1:0] = src_addr_i[i];
                w_sel.data[DataWidth-1:0] = src_data_i[i];
            end
        end
    end

    // A write to the hard-wired zero register is accepted but never issued.
    assign w_write = w_accept && !(ZeroRegZero && (w_sel.addr == '0));

    // Output stage: one write per accepted request, address/data hold otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we  <= 1'b0;
            r_out <= '0;
        end else begin
            r_we <= w_write;
            if (w_write) begin
                r_out <= w_sel;
            end
        end
    end

    assign we_o           = r_we;
    assign waddr_o        = r_out.addr[AddrWidth-1:0];
    assign wdata_o        = r_out.data[DataWidth-1:0];
    assign w_unused_stage = ^r_out;

    // Scoreboard set/clear vectors: clear on commit, set from issue.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int a = 0; a < Words; a++) begin
            w_set[a] = sb_set_valid_i && (sb_set_addr_i == AddrWidth'(a));
            w_clr[a] = r_we && (waddr_o == AddrWidth'(a));
        end
        if (ZeroRegZero) begin
            w_set[0] = 1'b0;
        end
    end

    // Busy bits: set wins over clear so a newer in-flight write stays tracked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign busy_o = r_busy;

`ifdef SNITCH_REGFILE_WRITEBACK_FWD_EN
    // Bypass the write landing this edge to matching read queries.
    always_comb begin
        fwd_hit_o  = '0;
        fwd_data_o = '0;
        for (int i = 0; i < NrReadPorts; i++) begin
            fwd_hit_o[i] = r_we && (waddr_o == fwd_raddr_i[i]) &&
                           !(ZeroRegZero && (waddr_o == '0));
            if (fwd_hit_o[i]) begin
                fwd_data_o[i] = wdata_o;
            end
        end
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^fwd_raddr_i;
    assign fwd_hit_o    = '0;
    assign fwd_data_o   = '0;
`endif

endmodule

// File: doc/snitch_regfile_writeback.md
Name: snitch_regfile_writeback

Overview:
- Write-side initiator for the Snitch integer/FP register file.
- Collects write-back requests from NrSources producers (ALU, LSU, accelerator/offload response, ...) over valid/ready, arbitrates round-robin, and drives the register file's single registered write port.
- Owns a busy scoreboard of destinations with writes in flight, used by issue logic for RAW/WAW hazard checks.

Parameters:
- NrSources, 3, number of write-back requesters (>=1)
- DataWidth, 32, register data width
- AddrWidth, 5, register address width; NumWords = 2**AddrWidth
- ZeroRegZero, 1, register 0 hard-wired zero: never busy, never written
- NrReadPorts, 2, forwarding query ports (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- src_valid_i  in  NrSources  write-back request valid
- src_ready_o  out  NrSources  request accepted this cycle
- src_addr_i  in  NrSources x AddrWidth  destination register
- src_data_i  in  NrSources x DataWidth  write data
- sb_set_valid_i  in  1  issue marks a destination busy
- sb_set_addr_i  in  AddrWidth  destination being marked busy
- busy_o  out  NumWords  per-register pending-write bits
- waddr_o  out  AddrWidth  register file write address
- wdata_o  out  DataWidth  register file write data
- we_o  out  1  register file write enable
- fwd_raddr_i  in  NrReadPorts x AddrWidth  forwarding query address (optional feature)
- fwd_hit_o  out  NrReadPorts  in-flight write matches query (optional feature)
- fwd_data_o  out  NrReadPorts x DataWidth  forwarded data (optional feature)

Behaviour:
- Reset: waddr_o=0, wdata_o=0, we_o=0, busy_o=0, round-robin pointer=0, fwd_hit_o=0.
- Arbitration:
  - Round-robin among asserted src_valid_i, starting at the pointer.
  - src_ready_o is one-hot or zero and depends combinationally on src_valid_i.
  - A request is accepted on the cycle where valid && ready; no other source is accepted that cycle.
  - After a grant to source k, the pointer moves to (k+1) mod NrSources. With no grant, the pointer holds.
- Valid/ready rules:
  - A requester keeps valid, addr and data stable until accepted.
  - ready never waits on a future cycle: the register file always accepts, so some valid source is granted every cycle.
- Output stage:
  - Single register stage; accepted in cycle N -> we_o=1 with that addr/data in cycle N+1.
  - Back-to-back acceptances give one write per cycle.
  - With no acceptance, we_o=0 next cycle; waddr_o/wdata_o hold their last value.
- ZeroRegZero=1, address 0:
  - The request is still accepted (ready may assert).
  - we_o stays 0 for it.
  - sb_set to register 0 is ignored and busy_o[0] is constantly 0.
- Scoreboard:
  - busy[a] is set on the clock edge where sb_set_valid_i && sb_set_addr_i==a.
  - busy[a] is cleared on the edge at the end of the cycle where we_o=1 && waddr_o==a (commit, not acceptance).
  - Set and clear of the same register in the same cycle: set wins (a newer write is in flight).
  - busy_o is a direct register output, with no combinational path from inputs.
- Accepting a write to a non-busy register is legal; it is not flagged and busy stays 0.
- Reset mid-operation: in-flight output-stage content is discarded (we_o=0); scoreboard and pointer are cleared immediately (asynchronous).

Optional Feature:
- Macro: SNITCH_REGFILE_WRITEBACK_FWD_EN.
- Defined:
  - fwd_hit_o[i] = we_o && waddr_o==fwd_raddr_i[i] && !(ZeroRegZero && waddr_o==0).
  - fwd_data_o[i] = wdata_o when hit, else 0.
  - Fully combinational from the output stage; lets the read stage bypass the write landing this edge.
- Undefined: fwd_hit_o and fwd_data_o are tied to 0. Ports remain, so the interface is identical either way.

Decomposition:
- Package snitch_regfile_writeback_pkg:
  - wb_req_t struct {addr, data}
  - function NumWords(AddrWidth)
- Sub-module snitch_regfile_writeback_rr_arb: round-robin pointer plus one-hot grant, parameterized on NrSources; instantiated once.
- Scoreboard and output stage stay in the top module.

Test Plan:
- Single write: source 1 valid, addr 5, data 0xDEADBEEF; sb_set 5 two cycles earlier. Expect:
  - ready[1] in cycle N
  - we_o=1, waddr_o=5, wdata_o=0xDEADBEEF in N+1
  - busy_o[5] 1 -> 0 after N+1
- Round-robin: all 3 sources valid continuously (addrs 1, 2, 3), pointer 0 -> grants 0, 1, 2, 0 on consecutive cycles; we_o high every cycle with addrs 1, 2, 3, 1.
- Set/clear collision: busy[7]=1; commit to 7 in the same cycle as sb_set 7 -> busy_o[7] stays 1; the next commit to 7 clears it.
- Zero register: ZeroRegZero=1, source 0 writes addr 0 data 0x1234; sb_set addr 0 -> accepted, we_o stays 0, busy_o[0] stays 0.
- Reset mid-write: assert rst_ni low while we_o=1 for addr 9 with busy[9]=1 -> we_o=0 and busy_o=0 immediately; no write after release.
- FWD_EN: fwd_raddr_i[0]=4, fwd_raddr_i[1]=6 while we_o writes addr 4 data 0xA5 -> fwd_hit_o=01, fwd_data_o[0]=0xA5; without the macro -> fwd_hit_o=00.
